// File: rtl/mem_wait_ctrl_if.sv
// Processor-side strobe/address/handshake bundle for mem_wait_ctrl.
// The shared 16-bit data bus stays a separate inout net so each side can tri-state it.
interface mem_wait_ctrl_if;
    logic        readMEM;
    logic        writeMEM;
    logic [15:0] addrBus;
    logic        readyMem;
    logic        accessErr;

    modport master (
        output readMEM, writeMEM, addrBus,
        input  readyMem, accessErr
    );

    modport slave (
        input  readMEM, writeMEM, addrBus,
        output readyMem, accessErr
    );
endinterface

// File: rtl/mem_wait_ctrl.sv
// Wait-state memory controller: captures one processor access, stalls WAIT_CYCLES,
// completes it with a one-cycle readyMem pulse, then waits for the strobes to drop.
module mem_wait_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 256
) (
    input  logic              clk,
    input  logic              rst,
    mem_wait_ctrl_if.slave    bus,
    inout  wire        [15:0] dataBus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            is_rd_q, is_rd_d;
    logic            err_q, err_d;
    logic            mem_we;
    logic            in_range;
    logic [15:0]     mem [DEPTH];

    assign in_range = 32'(bus.addrBus) < 32'(DEPTH);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        is_rd_d = is_rd_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.readMEM || bus.writeMEM) begin
                    addr_d  = bus.addrBus[AW-1:0];
                    wdata_d = dataBus;
                    is_rd_d = bus.readMEM;
                    err_d   = (bus.readMEM && bus.writeMEM) || !in_range;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Illegal accesses never touch the array and return zero.
                    mem_we  = !is_rd_q && !err_q;
                    rdata_d = err_q ? 16'h0000 : mem[addr_q];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = RELEASE;
            RELEASE: if (!bus.readMEM && !bus.writeMEM) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            is_rd_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_rd_q <= is_rd_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset; contents survive rst and start unknown.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= wdata_q;
    end

    assign bus.readyMem  = (state_q == DONE);
    assign bus.accessErr = (state_q == DONE) && err_q;
    assign dataBus       = ((state_q == DONE) && is_rd_q) ? rdata_q : 16'hzzzz;
endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Randomised plus directed bench for mem_wait_ctrl; DUT 0 uses WAIT_CYCLES=2, DUT 1 uses 0.
// Released data buses are pulled up, so a tri-stated bus reads as 16'hFFFF.
module tb_mem_wait_ctrl;
    localparam int W0 = 2;
    localparam int W1 = 0;

    logic        clk;
    logic        rst    [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [15:0] addr   [2];
    logic [15:0] tb_wd  [2];
    bit          tb_en  [2];
    logic        rdy    [2];
    logic        err    [2];
    logic [15:0] dbus   [2];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] ref_mem [2][256];

    wire [15:0] data_bus0;
    wire [15:0] data_bus1;
    pullup (data_bus0);
    pullup (data_bus1);
    assign data_bus0 = tb_en[0] ? tb_wd[0] : 16'hzzzz;
    assign data_bus1 = tb_en[1] ? tb_wd[1] : 16'hzzzz;

    mem_wait_ctrl_if bus0 ();
    mem_wait_ctrl_if bus1 ();

    assign bus0.readMEM  = rd[0];
    assign bus0.writeMEM = wr[0];
    assign bus0.addrBus  = addr[0];
    assign bus1.readMEM  = rd[1];
    assign bus1.writeMEM = wr[1];
    assign bus1.addrBus  = addr[1];
    assign rdy[0]  = bus0.readyMem;
    assign err[0]  = bus0.accessErr;
    assign rdy[1]  = bus1.readyMem;
    assign err[1]  = bus1.accessErr;
    assign dbus[0] = data_bus0;
    assign dbus[1] = data_bus1;

    mem_wait_ctrl #(.WAIT_CYCLES(W0), .DEPTH(256)) dut0 (
        .clk(clk), .rst(rst[0]), .bus(bus0), .dataBus(data_bus0)
    );
    mem_wait_ctrl #(.WAIT_CYCLES(W1), .DEPTH(256)) dut1 (
        .clk(clk), .rst(rst[1]), .bus(bus1), .dataBus(data_bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no summary expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: one access is either an error, a write to the word, or a read of it.
    task automatic model_access(input int d, input bit r, input bit w, input logic [15:0] a,
                                input logic [15:0] wd, output logic [15:0] exp_rd,
                                output bit exp_err);
        exp_rd  = 16'h0000;
        exp_err = (r && w) || (int'(a) >= 256);
        if (!exp_err) begin
            if (w) ref_mem[d][a[7:0]] = wd;
            else   exp_rd = ref_mem[d][a[7:0]];
        end
    endtask

    // Entered #1 after an edge with the DUT idle; leaves it idle #1 after an edge.
    task automatic do_access(input int d, input bit r, input bit w, input logic [15:0] a,
                             input logic [15:0] wd, input int hold, input string tag);
        logic [15:0] exp_rd;
        bit          exp_err;
        int          lat;
        lat = (d == 0) ? W0 : W1;
        model_access(d, r, w, a, wd, exp_rd, exp_err);
        rd[d] = r; wr[d] = w; addr[d] = a; tb_wd[d] = wd; tb_en[d] = w && !r;
        @(negedge clk);
        check($sformatf("%s/idle_rdy", tag), 16'(rdy[d]), 16'h0);
        if (!tb_en[d]) check($sformatf("%s/idle_bus", tag), dbus[d], 16'hFFFF);
        @(posedge clk); #1;
        addr[d] = 16'($urandom);
        if (tb_en[d]) tb_wd[d] = 16'($urandom);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            check($sformatf("%s/wait%0d_rdy", tag, c), 16'(rdy[d]), 16'h0);
            check($sformatf("%s/wait%0d_err", tag, c), 16'(err[d]), 16'h0);
            if (!tb_en[d]) check($sformatf("%s/wait%0d_bus", tag, c), dbus[d], 16'hFFFF);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check($sformatf("%s/done_rdy", tag), 16'(rdy[d]), 16'h1);
        check($sformatf("%s/done_err", tag), 16'(err[d]), 16'(exp_err));
        if (r) check($sformatf("%s/done_bus", tag), dbus[d], exp_rd);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("%s/hold%0d_rdy", tag, h), 16'(rdy[d]), 16'h0);
            if (!tb_en[d]) check($sformatf("%s/hold%0d_bus", tag, h), dbus[d], 16'hFFFF);
        end
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0; tb_en[d] = 1'b0;
        @(negedge clk);
        check($sformatf("%s/rel_rdy", tag), 16'(rdy[d]), 16'h0);
        check($sformatf("%s/rel_err", tag), 16'(err[d]), 16'h0);
        check($sformatf("%s/rel_bus", tag), dbus[d], 16'hFFFF);
        @(posedge clk); #1;
    endtask

    task automatic random_accesses(input int d, input int n);
        bit          r, w;
        int          k;
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            r = (k < 5) || (k == 9);
            w = (k >= 5);
            if ($urandom_range(0, 7) == 0) a = 16'(256 + $urandom_range(0, 65279));
            else                           a = 16'($urandom_range(0, 15));
            do_access(d, r, w, a, 16'($urandom), $urandom_range(0, 2),
                      $sformatf("rnd%0d_%0d", d, i));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = 16'h0000; tb_wd[d] = 16'h0000; tb_en[d] = 1'b0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset%0d_rdy", d), 16'(rdy[d]), 16'h0);
            check($sformatf("reset%0d_err", d), 16'(err[d]), 16'h0);
            check($sformatf("reset%0d_bus", d), dbus[d], 16'hFFFF);
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        for (int i = 0; i < 16; i++)
            do_access(0, 1'b0, 1'b1, 16'(i), 16'($urandom), 0, $sformatf("fill0_%0d", i));

        do_access(0, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 0, "wr_a5a5");
        do_access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, "rd_a5a5");
        do_access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 5, "rd_hold5");
        do_access(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 0, "rd_after_hold");

        do_access(0, 1'b0, 1'b1, 16'h0100, 16'hFFFF, 0, "wr_oob");
        do_access(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 0, "rd_oob");
        do_access(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, "rd_0_unchanged");

        do_access(0, 1'b1, 1'b1, 16'h0005, 16'hDEAD, 0, "both_strobes");
        do_access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 0, "rd_5_unchanged");

        do_access(0, 1'b0, 1'b1, 16'h0020, 16'h0001, 0, "wr_0001");
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'h0020; tb_wd[0] = 16'h7777; tb_en[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[0] = 1'b1; wr[0] = 1'b0; tb_en[0] = 1'b0;
        #1;
        check("rst_async_rdy", 16'(rdy[0]), 16'h0);
        check("rst_async_err", 16'(err[0]), 16'h0);
        check("rst_async_bus", dbus[0], 16'hFFFF);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rst_hold%0d_rdy", c), 16'(rdy[0]), 16'h0);
            check($sformatf("rst_hold%0d_bus", c), dbus[0], 16'hFFFF);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        do_access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 0, "rd_after_abort");

        random_accesses(0, 24);

        for (int i = 0; i < 16; i++)
            do_access(1, 1'b0, 1'b1, 16'(i), 16'($urandom), 0, $sformatf("fill1_%0d", i));
        do_access(1, 1'b0, 1'b1, 16'h0000, 16'h1234, 0, "w0_wr_1234");
        do_access(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, "w0_rd_1234");
        do_access(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 3, "w0_rd_hold");
        random_accesses(1, 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_wait_ctrl.md
MEM_WAIT_CTRL -- requirements
Module: mem_wait_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: idle cycles inserted between request capture and access completion (legal 0..15).
REQ-002 Parameter DEPTH, default 256: number of 16-bit words implemented, addresses 0..DEPTH-1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 readMEM  input  1  processor read strobe, held high until readyMem is seen.
REQ-006 writeMEM  input  1  processor write strobe, held high until readyMem is seen.
REQ-007 addrBus  input  16  word address from the processor.
REQ-008 dataBus  inout  16  shared data bus; the processor drives it for writes, this block drives it only for read return.
REQ-009 readyMem  output  1  one-cycle completion pulse for the current access.
REQ-010 accessErr  output  1  high with readyMem when the completed access was illegal (out-of-range address, or both strobes high).

Function
REQ-011 The block SHALL implement FSM states IDLE, WAIT, DONE, RELEASE.
REQ-012 IDLE: on a rising edge with readMEM or writeMEM high, the block SHALL capture addrBus, dataBus (write data), and strobe type, load the wait counter with WAIT_CYCLES, and enter WAIT.
REQ-013 WAIT: the counter SHALL decrement once per cycle; on the edge where it is 0, the access SHALL execute and the FSM SHALL enter DONE (WAIT_CYCLES=0 -> exactly one WAIT cycle).
REQ-014 Latency: for a request captured at edge N, readyMem SHALL be high for exactly the cycle after edge N+WAIT_CYCLES+1.
REQ-015 Write: the array word at the captured address SHALL be written with the captured data on the edge entering DONE.
REQ-016 Read: the array word SHALL be registered on the edge entering DONE and driven onto dataBus only while in DONE; dataBus SHALL be high-impedance in every other state.
REQ-017 DONE lasts one cycle, then RELEASE; RELEASE SHALL return to IDLE only on an edge where both strobes are low, so a held strobe is never accepted twice.
REQ-018 Address >= DEPTH: write SHALL be discarded, read SHALL return 16'h0000, accessErr SHALL be 1 in DONE.
REQ-019 Both strobes high at capture: no array access, read return 16'h0000, accessErr 1 in DONE, normal ready timing.
REQ-020 Strobe changes or addrBus/dataBus changes after capture SHALL have no effect on the access in flight.
REQ-021 accessErr SHALL be 0 in every state other than DONE.

Reset
REQ-022 While rst is high, the FSM SHALL be IDLE, counter 0, readyMem 0, accessErr 0, dataBus released (Z), with effect immediately, not at the next edge.
REQ-023 Reset asserted during WAIT SHALL abort the access; a pending write SHALL NOT reach the array.
REQ-024 Array contents SHALL NOT be cleared by reset; contents are unknown until written.
REQ-025 After rst falls, the first edge with a strobe high SHALL be captured as a new request (no RELEASE wait).

Verification
REQ-026 WAIT_CYCLES=2: write 16'hA5A5 to 16'h0010 captured at edge N -> readyMem high after edge N+3 only, accessErr 0; later read of 16'h0010 returns 16'hA5A5 on dataBus during readyMem.
REQ-027 WAIT_CYCLES=0: read of address 16'h0000 after writing 16'h1234 -> readyMem one cycle after edge N+1, dataBus 16'h1234, Z the cycles before and after.
REQ-028 Read strobe held 5 cycles past readyMem -> exactly one readyMem pulse; a new request is captured only after the strobe drops for an edge.
REQ-029 Write 16'hFFFF to 16'h0100 (DEPTH=256) -> readyMem with accessErr 1; read of 16'h0100 -> 16'h0000, accessErr 1; address 16'h0000 unchanged.
REQ-030 Both strobes high -> readyMem at normal latency with accessErr 1, array unchanged.
REQ-031 rst pulsed mid-WAIT of write 16'h7777 to 16'h0020 (previously 16'h0001) -> readyMem never pulses, dataBus Z, subsequent read of 16'h0020 returns 16'h0001.
